// File: rtl/ysyx22041405_bpu.sv
// Fetch-side next-PC unit: owns the fetch PC, predicts the next PC through a direct-mapped
// BTB with 2-bit direction counters, and redirects on execute-stage mispredicts.
module ysyx22041405_bpu #(
    parameter int               WIDTH    = 32,
    parameter int               ENTRIES  = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_target,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] br_cnt,
    output logic [WIDTH-1:0] miss_cnt
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] br_cnt_q;
    logic [WIDTH-1:0] miss_cnt_q;

    logic             valid_q [ENTRIES];
    logic [TW-1:0]    tag_q   [ENTRIES];
    logic [WIDTH-1:0] tgt_q   [ENTRIES];
    logic             jmp_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX-1:0]   f_idx;
    logic             f_hit;
    logic [IDX-1:0]   e_idx;
    logic [TW-1:0]    e_tag;
    logic             e_hit;
    logic             resolve;
    logic             act_taken;
    logic [WIDTH-1:0] ex_seq;
    logic [WIDTH-1:0] tgt_clean;
    logic [WIDTH-1:0] correct;
    logic             mispredict;
    logic             alias_miss;

    // Fetch-side lookup reads the pre-edge table contents; there is no write bypass.
    assign f_idx       = pc_q[IDX+1:2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == pc_q[WIDTH-1:IDX+2]);
    assign pred_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    assign pred_target = f_hit ? tgt_q[f_idx] : pc_q + FOUR;

    assign e_idx     = ex_pc[IDX+1:2];
    assign e_tag     = ex_pc[WIDTH-1:IDX+2];
    assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign resolve   = ex_valid && (ex_is_branch || ex_is_jump);
    assign act_taken = ex_is_jump || ex_taken;
    assign ex_seq    = ex_pc + FOUR;
    assign tgt_clean = ex_target & ~ONE;
    assign correct   = act_taken ? tgt_clean : ex_seq;

    assign mispredict = resolve &&
                        ((ex_pred_taken != act_taken) || (act_taken && (ex_pred_target != correct)));
    // A non-control instruction predicted taken means a stale BTB entry aliased onto it.
    assign alias_miss = ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken;

    assign redirect    = mispredict || alias_miss;
    assign redirect_pc = alias_miss ? ex_seq : correct;

    assign pc       = pc_q;
    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
        end else if (fetch_ready) begin
            pc_q <= pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + ONE;
            end
            if (redirect && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                jmp_q[i]   <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (resolve) begin
            if (e_hit) begin
                if (act_taken) begin
                    tgt_q[e_idx] <= tgt_clean;
                    if (ctr_q[e_idx] != 2'b11) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                    end
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
                end
                jmp_q[e_idx] <= ex_is_jump;
            end else if (act_taken) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= tgt_clean;
                jmp_q[e_idx]   <= ex_is_jump;
                ctr_q[e_idx]   <= 2'b10;
            end
        end else if (alias_miss && e_hit) begin
            valid_q[e_idx] <= 1'b0;
        end
    end
endmodule
